status_led_ctrl: RTL and testbench
==================================

Name: status_led_ctrl

Overview:
- Parametrised successor to the board status-LED driver: maps controller status levels and event pulses onto two RGB LEDs.
- LED0 shows system state from a priority FSM; LED1 shows pulse-stretched error/success flashes.
- All colour outputs are PWM-dimmed by a run-time brightness value; saturating error counter for debug.
- Sits between the ADC/command controller status signals and the board RGB LED pins.

Parameters:
PWM_BITS, 8, width of PWM counter and i_brightness
BLINK_HALF_CYCLES, 25000000, cycles per half-period of the boot blink
STRETCH_CYCLES, 12500000, cycles an event flash is held on LED1
ERR_CNT_W, 8, width of o_err_count

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_init_done  in  1  level, ADC init complete
i_idle  in  1  level, controller idle
i_wait_cmd  in  1  level, waiting for command
i_error  in  1  event, any width >= 1 cycle
i_succes  in  1  event, any width >= 1 cycle
i_brightness  in  PWM_BITS  PWM duty, 0 = dark
i_clear  in  1  clears error count (and sticky error, see option)
o_led0_r / o_led0_g / o_led0_b  out  1 each  LED0 colour
o_led1_r / o_led1_g / o_led1_b  out  1 each  LED1 colour
o_err_count  out  ERR_CNT_W  number of error rising edges, saturating

Behaviour:
- One clock domain (i_clock); reset is synchronous, active-high. On i_reset all six LED outputs = 0, o_err_count = 0, PWM/blink/stretch counters = 0, LED0 FSM = BOOT, LED1 FSM = OFF.
- Event detection: i_error and i_succes are edge-detected (registered previous value); only rising edges act. A level held high produces one event.
- LED0 FSM, evaluated every cycle, priority top-down: !i_init_done -> BOOT; i_wait_cmd -> WAIT; i_idle -> IDLE; else BUSY.
- LED0 colours: BOOT = blue, blinking (toggles every BLINK_HALF_CYCLES, starts ON after reset); WAIT = cyan (g+b); IDLE = green; BUSY = yellow (r+g). Blink counter resets on entering BOOT.
- LED1 FSM states: OFF, ERR (red), OK (green).
  - Error edge: -> ERR from any state, stretch counter reloads to STRETCH_CYCLES.
  - Success edge: from OFF or OK -> OK, counter reloads (retrigger extends). In ERR it is ignored.
  - Same-cycle error and success edges: error wins.
  - Counter reaching 0 in ERR or OK -> OFF.
- PWM: free-running PWM_BITS counter, wrap at 2^PWM_BITS-1 -> 0. Enable = (pwm_cnt < i_brightness). Brightness 0 = always dark; all-ones = on 2^PWM_BITS-1 of every 2^PWM_BITS cycles. Each output = colour bit AND enable.
- All LED outputs are registered: one cycle from an input change or edge to the output.
- o_err_count increments on each error edge and saturates at all-ones. i_clear zeroes it next cycle; same-cycle clear and error edge gives a count of 0.
- Status inputs are already synchronous to i_clock; no synchronisers inside.

Optional Feature:
STATUS_LED_ERR_STICKY_EN
- Defined: ERR state does not time out; LED1 stays red until i_clear (-> OFF next cycle). i_clear in the same cycle as an error edge: error wins, LED1 stays ERR, count = 0.
- Undefined: ERR times out after STRETCH_CYCLES as above; i_clear affects only o_err_count.

Test Plan:
Test parameters: PWM_BITS=4, BLINK_HALF_CYCLES=8, STRETCH_CYCLES=20, brightness=15.
1. Reset 3 cycles, i_init_done=0 -> all outputs 0 during reset; then o_led0_b on for 15 of 16 cycles in PWM windows, toggling every 8 cycles; r=g=0.
2. i_init_done=1, i_idle=1 -> LED0 green. Then i_wait_cmd=1 -> cyan. Then i_wait_cmd=0, i_idle=0 -> yellow. Each change is visible 1 cycle later.
3. i_error pulse 15 cycles -> LED1 red for 20 cycles then off; o_err_count=1 (not 15).
4. i_succes at t, again at t+10 -> LED1 green until t+30. i_succes during red -> stays red. Error and success in the same cycle -> red.
5. i_brightness=0 -> all outputs 0 regardless of state. i_brightness=4 -> each lit output high exactly 4 of 16 cycles.
6. 300 error edges with ERR_CNT_W=8 -> o_err_count=255; i_clear -> 0. With STATUS_LED_ERR_STICKY_EN: red persists past 20 cycles until i_clear.

Source files
------------

// File: rtl/status_led_ctrl.sv
// Status LED driver: LED0 shows controller state, LED1 shows stretched error/success flashes, all PWM-dimmed.
// Define STATUS_LED_ERR_STICKY_EN to hold the red error flash until i_clear instead of timing out.
module status_led_ctrl #(
    parameter int PWM_BITS          = 8,
    parameter int BLINK_HALF_CYCLES = 25000000,
    parameter int STRETCH_CYCLES    = 12500000,
    parameter int ERR_CNT_W         = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_init_done,
    input  logic                 i_idle,
    input  logic                 i_wait_cmd,
    input  logic                 i_error,
    input  logic                 i_succes,
    input  logic [PWM_BITS-1:0]  i_brightness,
    input  logic                 i_clear,
    output logic                 o_led0_r,
    output logic                 o_led0_g,
    output logic                 o_led0_b,
    output logic                 o_led1_r,
    output logic                 o_led1_g,
    output logic                 o_led1_b,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    // state   | meaning
    // BOOT    | init not done, LED0 blue blinking
    // WAIT    | waiting for command, LED0 cyan
    // IDLE    | controller idle, LED0 green
    // BUSY    | working, LED0 yellow
    // OFF     | LED1 dark
    // ERR     | LED1 red, stretched error flash
    // OK      | LED1 green, stretched success flash

    localparam int BLINK_W   = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_HALF_CYCLES - 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES);
    localparam logic [STRETCH_W-1:0] STRETCH_ONE  = STRETCH_W'(1);

    typedef enum logic [1:0] {
        S0_BOOT,
        S0_WAIT,
        S0_IDLE,
        S0_BUSY
    } led0_state_t;

    typedef enum logic [1:0] {
        S1_OFF,
        S1_ERR,
        S1_OK
    } led1_state_t;

    led0_state_t            led0_state;
    led0_state_t            led0_next;
    led1_state_t            led1_state;
    led1_state_t            led1_next;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [BLINK_W-1:0]     blink_cnt;
    logic [BLINK_W-1:0]     blink_cnt_next;
    logic                   blink_on;
    logic                   blink_on_next;
    logic [STRETCH_W-1:0]   stretch_cnt;
    logic [STRETCH_W-1:0]   stretch_next;
    logic                   error_prev;
    logic                   succes_prev;
    logic                   error_edge;
    logic                   succes_edge;
    logic                   pwm_en;
    logic [2:0]             colour0;
    logic [2:0]             colour1;
    logic [ERR_CNT_W-1:0]   err_cnt;
    logic [ERR_CNT_W-1:0]   err_cnt_next;

    assign error_edge  = i_error & ~error_prev;
    assign succes_edge = i_succes & ~succes_prev;
    assign pwm_en      = (pwm_cnt < i_brightness);
    assign o_err_count = err_cnt;

    // Blink counter idles at (0, on) outside BOOT, so entering BOOT always starts a fresh ON half-period.
    always_comb begin
        led0_next      = S0_BUSY;
        blink_cnt_next = '0;
        blink_on_next  = 1'b1;
        colour0        = 3'b000;
        if (!i_init_done) begin
            led0_next = S0_BOOT;
        end else if (i_wait_cmd) begin
            led0_next = S0_WAIT;
        end else if (i_idle) begin
            led0_next = S0_IDLE;
        end
        if (led0_next == S0_BOOT) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next = '0;
                blink_on_next  = ~blink_on;
            end else begin
                blink_cnt_next = blink_cnt + BLINK_W'(1);
                blink_on_next  = blink_on;
            end
        end
        case (led0_next)
            S0_BOOT: colour0 = {2'b00, blink_on};
            S0_WAIT: colour0 = 3'b011;
            S0_IDLE: colour0 = 3'b010;
            default: colour0 = 3'b110;
        endcase
    end

    always_comb begin
        led1_next    = led1_state;
        stretch_next = stretch_cnt;
        colour1      = 3'b000;
        if (error_edge) begin
            led1_next    = S1_ERR;
            stretch_next = STRETCH_LOAD;
        end else begin
            case (led1_state)
                S1_ERR: begin
`ifdef STATUS_LED_ERR_STICKY_EN
                    if (i_clear) begin
                        led1_next    = S1_OFF;
                        stretch_next = '0;
                    end
`else
                    if (stretch_cnt <= STRETCH_ONE) begin
                        led1_next    = S1_OFF;
                        stretch_next = '0;
                    end else begin
                        stretch_next = stretch_cnt - STRETCH_ONE;
                    end
`endif
                end
                S1_OK: begin
                    if (succes_edge) begin
                        stretch_next = STRETCH_LOAD;
                    end else if (stretch_cnt <= STRETCH_ONE) begin
                        led1_next    = S1_OFF;
                        stretch_next = '0;
                    end else begin
                        stretch_next = stretch_cnt - STRETCH_ONE;
                    end
                end
                default: begin
                    if (succes_edge) begin
                        led1_next    = S1_OK;
                        stretch_next = STRETCH_LOAD;
                    end
                end
            endcase
        end
        case (led1_next)
            S1_ERR:  colour1 = 3'b100;
            S1_OK:   colour1 = 3'b010;
            default: colour1 = 3'b000;
        endcase
    end

    // Clear has priority over a same-cycle error edge.
    always_comb begin
        err_cnt_next = err_cnt;
        if (i_clear) begin
            err_cnt_next = '0;
        end else if (error_edge && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt_next = err_cnt + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            led0_state  <= S0_BOOT;
            led1_state  <= S1_OFF;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            stretch_cnt <= '0;
            error_prev  <= 1'b0;
            succes_prev <= 1'b0;
            err_cnt     <= '0;
            {o_led0_r, o_led0_g, o_led0_b} <= 3'b000;
            {o_led1_r, o_led1_g, o_led1_b} <= 3'b000;
        end else begin
            led0_state  <= led0_next;
            led1_state  <= led1_next;
            pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
            blink_cnt   <= blink_cnt_next;
            blink_on    <= blink_on_next;
            stretch_cnt <= stretch_next;
            error_prev  <= i_error;
            succes_prev <= i_succes;
            err_cnt     <= err_cnt_next;
            {o_led0_r, o_led0_g, o_led0_b} <= colour0 & {3{pwm_en}};
            {o_led1_r, o_led1_g, o_led1_b} <= colour1 & {3{pwm_en}};
        end
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl with small parameters (PWM 4 bits, blink 8, stretch 20).
// Expected LED values come from a PWM phase counter kept by the bench and hand-derived colour tables.
module tb_status_led_ctrl;

    localparam int PW = 4;
    localparam int BH = 8;
    localparam int SC = 20;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          idle;
    logic          wait_cmd;
    logic          error;
    logic          succes;
    logic [PW-1:0] bright;
    logic          clear;
    logic          led0_r, led0_g, led0_b;
    logic          led1_r, led1_g, led1_b;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    int ph    = 0;
    int hits_r = 0;
    int hits_g = 0;

    status_led_ctrl #(
        .PWM_BITS(PW),
        .BLINK_HALF_CYCLES(BH),
        .STRETCH_CYCLES(SC),
        .ERR_CNT_W(EW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_init_done(init_done),
        .i_idle(idle),
        .i_wait_cmd(wait_cmd),
        .i_error(error),
        .i_succes(succes),
        .i_brightness(bright),
        .i_clear(clear),
        .o_led0_r(led0_r),
        .o_led0_g(led0_g),
        .o_led0_b(led0_b),
        .o_led1_r(led1_r),
        .o_led1_g(led1_g),
        .o_led1_b(led1_b),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    // One clock: inputs set before the call are sampled at the posedge, outputs read at the negedge.
    task automatic cyc();
        @(negedge clk);
        ph = ecnt % 16;
        ecnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [2:0] colour);
        logic en;
        en = (ph < int'(bright));
        chk(tag, 32'({led0_r, led0_g, led0_b}), 32'(colour & {3{en}}));
    endtask

    task automatic chk1(input string tag, input logic [2:0] colour);
        logic en;
        en = (ph < int'(bright));
        chk(tag, 32'({led1_r, led1_g, led1_b}), 32'(colour & {3{en}}));
    endtask

    initial begin
        rst = 1'b1; init_done = 1'b0; idle = 1'b0; wait_cmd = 1'b0;
        error = 1'b0; succes = 1'b0; clear = 1'b0; bright = 4'd15;

        repeat (3) begin
            cyc();
            chk("reset_leds", 32'({led0_r, led0_g, led0_b, led1_r, led1_g, led1_b}), 32'd0);
        end
        chk("reset_count", 32'(err_count), 32'd0);

        rst = 1'b0;
        ecnt = 0;
        for (int n = 0; n < 32; n++) begin
            cyc();
            chk0("boot_blink", ((n / 8) % 2 == 0) ? 3'b001 : 3'b000);
        end

        init_done = 1'b1; idle = 1'b1;
        cyc(); chk0("idle_green", 3'b010);
        wait_cmd = 1'b1;
        cyc(); chk0("wait_cyan", 3'b011);
        wait_cmd = 1'b0; idle = 1'b0;
        cyc(); chk0("busy_yellow", 3'b110);
        init_done = 1'b0;
        cyc(); chk0("reboot_blue", 3'b001);
        init_done = 1'b1;
        cyc(); chk0("busy_again", 3'b110);

        for (int k = 0; k < 25; k++) begin
            error = (k < 15);
            cyc();
            chk1("err_stretch", (k < 20) ? 3'b100 : 3'b000);
        end
        chk("err_count_1", 32'(err_count), 32'd1);

        for (int k = 0; k < 35; k++) begin
            succes = (k == 0 || k == 10);
            cyc();
            chk1("ok_retrigger", (k < 30) ? 3'b010 : 3'b000);
        end

        for (int k = 0; k < 25; k++) begin
            error  = (k == 0);
            succes = (k == 3);
            cyc();
            chk1("succ_in_err", (k < 20) ? 3'b100 : 3'b000);
        end

        error = 1'b1; succes = 1'b1;
        cyc(); chk1("err_wins", 3'b100);
        error = 1'b0; succes = 1'b0;
        repeat (25) cyc();
        chk1("err_wins_off", 3'b000);
        chk("err_count_3", 32'(err_count), 32'd3);

        bright = 4'd4;
        for (int k = 0; k < 16; k++) begin
            cyc();
            hits_r += int'(led0_r);
            hits_g += int'(led0_g);
            chk0("dim4", 3'b110);
        end
        chk("dim4_r_hits", 32'(hits_r), 32'd4);
        chk("dim4_g_hits", 32'(hits_g), 32'd4);

        bright = 4'd0;
        for (int k = 0; k < 16; k++) begin
            error = (k == 0);
            cyc();
            chk("dark", 32'({led0_r, led0_g, led0_b, led1_r, led1_g, led1_b}), 32'd0);
        end
        bright = 4'd15;
        cyc(); chk1("red_after_dark", 3'b100);
        chk("err_count_4", 32'(err_count), 32'd4);

        for (int i = 0; i < 100; i++) begin
            error = 1'b1; cyc();
            error = 1'b0; cyc();
        end
        chk("err_count_mid", 32'(err_count), 32'd104);
        for (int i = 0; i < 200; i++) begin
            error = 1'b1; cyc();
            error = 1'b0; cyc();
        end
        chk("err_count_sat", 32'(err_count), 32'd255);

        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("err_clear", 32'(err_count), 32'd0);
        repeat (25) cyc();

        clear = 1'b1; error = 1'b1;
        cyc();
        chk("clear_vs_edge", 32'(err_count), 32'd0);
        chk1("clear_err_red", 3'b100);
        clear = 1'b0; error = 1'b0;

`ifdef STATUS_LED_ERR_STICKY_EN
        for (int k = 1; k < 30; k++) begin
            cyc();
            chk1("sticky_hold", 3'b100);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk1("sticky_clear", 3'b000);
`else
        for (int k = 1; k < 25; k++) begin
            cyc();
            chk1("err_timeout", (k < 20) ? 3'b100 : 3'b000);
        end
`endif
        chk("count_after", 32'(err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
